// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    // Controller states; encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width: one spare bit so WIDTH=1 and powers of two need no wrap handling.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Launch/result handshake between a requester and the serial adder.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;

    modport master (
        output start, A, B, ci,
        input  busy, done, s, co
    );

    modport slave (
        input  start, A, B, ci,
        output busy, done, s, co
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder_1b.sv
// One-bit full adder cell shared across all bit positions.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of a single bit slice.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell iterated LSB first over WIDTH cycles.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic             accept;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    full_adder_1b u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // Sum bits enter op_a's vacated MSB, so after WIDTH shifts op_a holds the sum.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = fa_s;
        end else begin : g_wn
            assign sum_next = {fa_s, op_a[WIDTH-1:1]};
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Operand capture, per-bit shift/carry update and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s_q   <= '0;
            co_q  <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.A;
            op_b  <= bus.B;
            carry <= bus.ci;
            cnt   <= '0;
        end else if (state_q == ST_RUN) begin
            op_a  <= sum_next;
            op_b  <= op_b >> 1;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                s_q  <= sum_next;
                co_q <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.start = 1'b1;
        bus8.A     = a;
        bus8.B     = b;
        bus8.ci    = c;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic run_checks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'({bus8.busy, bus8.done}), 32'b10);
            @(negedge clk);
        end
    endtask

    task automatic expect_done(input logic [7:0] es, input logic ec, input string tag);
        chk({tag, "_done"}, 32'({bus8.busy, bus8.done}), 32'b01);
        chk({tag, "_s"}, 32'(bus8.s), 32'(es));
        chk({tag, "_co"}, 32'(bus8.co), 32'(ec));
        @(negedge clk);
        chk({tag, "_idle"}, 32'({bus8.busy, bus8.done}), 32'b00);
        chk({tag, "_hold"}, 32'({bus8.co, bus8.s}), 32'({ec, es}));
    endtask

    // {co,s} expected for index {a,b,ci}
    logic [1:0] exp1 [8];

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp1       = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n      = 1'b0;
        bus8.start = 1'b1;
        bus8.A     = 8'h05;
        bus8.B     = 8'h03;
        bus8.ci    = 1'b1;
        bus1.start = 1'b0;
        bus1.A     = 1'b0;
        bus1.B     = 1'b0;
        bus1.ci    = 1'b0;

        // Reset held with start asserted
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", 32'({bus8.busy, bus8.done, bus8.co, bus8.s}), 32'd0);
        end
        rst_n      = 1'b1;
        bus8.start = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 32'({bus8.busy, bus8.done}), 32'b00);

        // 5 + 3
        launch8(8'h05, 8'h03, 1'b0);
        run_checks(8, "add53_busy");
        expect_done(8'h08, 1'b0, "add53");

        // Full carry ripple
        launch8(8'hFF, 8'h01, 1'b0);
        run_checks(8, "ripple1_busy");
        expect_done(8'h00, 1'b1, "ripple1");

        launch8(8'hFF, 8'hFF, 1'b1);
        run_checks(8, "ripple2_busy");
        expect_done(8'hFF, 1'b1, "ripple2");

        // start and new operands mid-RUN are ignored
        launch8(8'h12, 8'h34, 1'b0);
        run_checks(2, "ignore_busy");
        bus8.start = 1'b1;
        bus8.A     = 8'hFF;
        bus8.B     = 8'hFF;
        bus8.ci    = 1'b1;
        run_checks(1, "ignore_busy");
        bus8.start = 1'b0;
        run_checks(5, "ignore_busy");
        expect_done(8'h46, 1'b0, "ignore");

        // start held through DONE launches a second add
        bus8.start = 1'b1;
        bus8.A     = 8'h05;
        bus8.B     = 8'h03;
        bus8.ci    = 1'b0;
        @(negedge clk);
        bus8.A     = 8'h10;
        bus8.B     = 8'h20;
        bus8.ci    = 1'b1;
        run_checks(8, "b2b_first_busy");
        chk("b2b_first_done", 32'({bus8.busy, bus8.done}), 32'b01);
        chk("b2b_first_s", 32'({bus8.co, bus8.s}), 32'h008);
        @(negedge clk);
        bus8.start = 1'b0;
        chk("b2b_busy_after_done", 32'({bus8.busy, bus8.done}), 32'b10);
        run_checks(8, "b2b_second_busy");
        expect_done(8'h31, 1'b0, "b2b_second");

        // Reset in RUN cycle 4 aborts the addition
        launch8(8'h5A, 8'h33, 1'b0);
        run_checks(3, "abort_busy");
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 32'({bus8.busy, bus8.done, bus8.co, bus8.s}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            chk("abort_no_done", 32'({bus8.done, bus8.co, bus8.s}), 32'd0);
            @(negedge clk);
        end
        launch8(8'h10, 8'h20, 1'b0);
        run_checks(8, "after_abort_busy");
        expect_done(8'h30, 1'b0, "after_abort");

        // WIDTH=1: full-adder truth table, done two cycles after start
        for (int i = 0; i < 8; i++) begin
            bus1.start = 1'b1;
            bus1.A     = i[2];
            bus1.B     = i[1];
            bus1.ci    = i[0];
            @(negedge clk);
            bus1.start = 1'b0;
            chk("w1_busy", 32'({bus1.busy, bus1.done}), 32'b10);
            @(negedge clk);
            chk("w1_done", 32'({bus1.busy, bus1.done}), 32'b01);
            chk("w1_sum", 32'({bus1.co, bus1.s}), 32'(exp1[i]));
            @(negedge clk);
            chk("w1_idle", 32'({bus1.busy, bus1.done}), 32'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
